// File: rtl/gpio_wrap_pkg.sv
// gpio_wrap_pkg: shared types, defaults and helpers for the GPIO select wrapper
package gpio_wrap_pkg;
  localparam int DEF_NUM_DESIGNS = 4;
  localparam int DEF_GPIO_W = 34;
  localparam int DEF_DYN_W = 8;
  localparam int DEF_GUARD_CYCLES = 4;
  localparam int MAX_DESIGNS = 16;
  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;
  function automatic logic [MAX_DESIGNS-1:0] onehot_dec(input int idx);
    return MAX_DESIGNS'(1) << idx;
  endfunction
endpackage

// File: rtl/cs_sync2.sv
// cs_sync2: two-flop synchroniser for an asynchronous level, resets to 0
module cs_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async level through two flops
  always_ff @(posedge clk)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/gpio_select_wrapper.sv
// gpio_select_wrapper: shares one GPIO pin bank among several designs with guarded switching
module gpio_select_wrapper
  import gpio_wrap_pkg::*;
#(
  parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
  parameter int GPIO_W = DEF_GPIO_W,
  parameter int SEL_W = $clog2(NUM_DESIGNS),
  parameter int DYN_W = DEF_DYN_W,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ncs,
  input  logic [SEL_W-1:0]              design_sel,
  input  logic [GPIO_W-1:0]             gpio_in,
  output logic [GPIO_W-1:0]             gpio_out,
  output logic [GPIO_W-1:0]             gpio_oeb,
  input  logic [NUM_DESIGNS*GPIO_W-1:0] des_gpo,
  input  logic [NUM_DESIGNS*GPIO_W-1:0] des_oeb_mask,
  input  logic [NUM_DESIGNS-1:0]        des_dyn_en,
  output logic [NUM_DESIGNS-1:0]        des_cs,
  output logic [GPIO_W-1:0]             des_gpi,
  output logic                          active,
  output logic                          sel_err
);
  localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GUARD_CYCLES - 1);
  state_t state, state_n;
  logic [SEL_W-1:0] cur_sel, cur_sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic cs_s, sel_ok, sel_new;
  logic [GPIO_W-1:0] oeb_n;
  cs_sync2 u_sync (.clk, .rst, .d(~ncs), .q(cs_s));
  assign sel_ok = 32'(design_sel) < NUM_DESIGNS;
  assign sel_new = sel_ok && design_sel != cur_sel;
  assign active = state == ACTIVE;
  assign des_cs = active ? NUM_DESIGNS'(onehot_dec(32'(cur_sel))) : '0;
  assign des_gpi = active ? gpio_in : '0;
  // next state: cs drop beats bad select beats design switch beats guard countdown
  always_comb begin
    state_n = state;
    cur_sel_n = cur_sel;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (cs_s && sel_ok) begin
        state_n = GUARD;
        cur_sel_n = design_sel;
        cnt_n = RELOAD;
      end
    end else if (!cs_s || !sel_ok) state_n = IDLE;
    else if (sel_new) begin
      state_n = GUARD;
      cur_sel_n = design_sel;
      cnt_n = RELOAD;
    end else if (state == GUARD) begin
      state_n = cnt == '0 ? ACTIVE : GUARD;
      cnt_n = cnt == '0 ? cnt : cnt - CNT_W'(1);
    end
  end
  // state, selection and guard counter registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur_sel <= '0;
      cnt <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_n;
      cur_sel <= cur_sel_n;
      cnt <= cnt_n;
      sel_err <= cs_s && !sel_ok;
    end
  // low pins follow the design's dynamic enable, the rest its static mask
  always_comb begin
    oeb_n = des_oeb_mask[32'(cur_sel)*GPIO_W +: GPIO_W];
    for (int i = 0; i < DYN_W; i++) oeb_n[i] = ~des_dyn_en[cur_sel];
  end
  // registered pins, tri-stated whenever no design is active
  always_ff @(posedge clk)
    if (rst) begin
      gpio_out <= '0;
      gpio_oeb <= '1;
    end else begin
      gpio_out <= active ? des_gpo[32'(cur_sel)*GPIO_W +: GPIO_W] : '0;
      gpio_oeb <= active ? oeb_n : '1;
    end
endmodule

// File: tb/tb_gpio_select_wrapper.sv
// tb_gpio_select_wrapper: scoreboard bench with a run-length reference model for two configurations
module tb_gpio_select_wrapper;
  typedef struct { bit d1, d2, act; int run, rsel; } ms_t;
  typedef struct { bit act, err; logic [3:0] cs; logic [33:0] out, oeb, gpi; } ex_t;
  logic clk = 0, rst = 1, ncs = 1;
  logic [1:0] design_sel = 0;
  logic [33:0] gpio_in = 0;
  logic [135:0] des_gpo = 0, des_oeb_mask = '1;
  logic [3:0] des_dyn_en = 0;
  logic [33:0] gpio_out_a, gpio_oeb_a, des_gpi_a, gpio_out_b, gpio_oeb_b, des_gpi_b;
  logic [3:0] des_cs_a;
  logic [2:0] des_cs_b;
  logic active_a, sel_err_a, active_b, sel_err_b;
  int checks = 0, errors = 0;
  ex_t qa[$], qb[$];
  always #5 clk = ~clk;
  gpio_select_wrapper u_a (
    .clk(clk), .rst(rst), .ncs(ncs), .design_sel(design_sel), .gpio_in(gpio_in),
    .gpio_out(gpio_out_a), .gpio_oeb(gpio_oeb_a), .des_gpo(des_gpo), .des_oeb_mask(des_oeb_mask),
    .des_dyn_en(des_dyn_en), .des_cs(des_cs_a), .des_gpi(des_gpi_a), .active(active_a), .sel_err(sel_err_a)
  );
  gpio_select_wrapper #(.NUM_DESIGNS(3)) u_b (
    .clk(clk), .rst(rst), .ncs(ncs), .design_sel(design_sel), .gpio_in(gpio_in),
    .gpio_out(gpio_out_b), .gpio_oeb(gpio_oeb_b), .des_gpo(des_gpo[101:0]), .des_oeb_mask(des_oeb_mask[101:0]),
    .des_dyn_en(des_dyn_en[2:0]), .des_cs(des_cs_b), .des_gpi(des_gpi_b), .active(active_b), .sel_err(sel_err_b)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // a design is active once the last five edges all saw cs asserted with the same valid select
  task automatic step(input int n, input ms_t mi, output ms_t mo, output ex_t e);
    bit cs, ok;
    mo = mi;
    cs = mi.d2;
    ok = design_sel < n;
    if (rst) begin
      mo.d1 = 0;
      mo.d2 = 0;
      mo.run = 0;
      e.out = 0;
      e.oeb = '1;
      e.err = 0;
    end else begin
      e.err = cs && !ok;
      if (mi.act) begin
        e.out = des_gpo[mi.rsel*34 +: 34];
        e.oeb = des_oeb_mask[mi.rsel*34 +: 34];
        e.oeb[7:0] = des_dyn_en[mi.rsel] ? 8'h00 : 8'hFF;
      end else begin
        e.out = 0;
        e.oeb = '1;
      end
      if (cs && ok) begin
        mo.run = (mi.run > 0 && design_sel == mi.rsel) ? (mi.run < 99 ? mi.run + 1 : 99) : 1;
        mo.rsel = design_sel;
      end else mo.run = 0;
      mo.d2 = mi.d1;
      mo.d1 = !ncs;
    end
    mo.act = mo.run >= 5;
    e.act = mo.act;
    e.cs = mo.act ? 4'(1 << mo.rsel) : 4'h0;
    e.gpi = mo.act ? gpio_in : 34'h0;
  endtask
  initial begin
    ms_t ma, mb, t;
    ex_t ea, eb;
    ma = '{default: 0};
    mb = ma;
    forever begin
      @(posedge clk);
      step(4, ma, t, ea);
      ma = t;
      step(3, mb, t, eb);
      mb = t;
      qa.push_back(ea);
      qb.push_back(eb);
    end
  end
  initial begin
    ex_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_active", 64'(active_a), 64'(e.act));
        chk("a_des_cs", 64'(des_cs_a), 64'(e.cs));
        chk("a_gpio_out", 64'(gpio_out_a), 64'(e.out));
        chk("a_gpio_oeb", 64'(gpio_oeb_a), 64'(e.oeb));
        chk("a_sel_err", 64'(sel_err_a), 64'(e.err));
        chk("a_des_gpi", 64'(des_gpi_a), 64'(e.gpi));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_active", 64'(active_b), 64'(e.act));
        chk("b_des_cs", 64'(des_cs_b), 64'(e.cs));
        chk("b_gpio_out", 64'(gpio_out_b), 64'(e.out));
        chk("b_gpio_oeb", 64'(gpio_oeb_b), 64'(e.oeb));
        chk("b_sel_err", 64'(sel_err_b), 64'(e.err));
        chk("b_des_gpi", 64'(des_gpi_b), 64'(e.gpi));
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_active(input bit use_b, output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!(use_b ? active_b : active_a) && n < 20);
  endtask
  initial begin
    int n;
    tick;
    tick;
    rst = 0;
    repeat (10) tick;
    chk("idle_oeb", 64'(gpio_oeb_a), 64'h3_FFFF_FFFF);
    chk("idle_out", 64'(gpio_out_a), 64'h0);
    chk("idle_cs", 64'(des_cs_a), 64'h0);
    chk("idle_active", 64'(active_a), 64'h0);
    des_gpo[68 +: 34] = 34'h1_2345_6789;
    des_oeb_mask[68 +: 34] = 34'h0;
    des_dyn_en[2] = 1;
    design_sel = 2;
    ncs = 0;
    wait_active(0, n);
    chk("act_latency", 64'(n), 64'd7);
    chk("act_cs", 64'(des_cs_a), 64'b0100);
    tick;
    chk("act_out", 64'(gpio_out_a), 64'h1_2345_6789);
    chk("act_oeb", 64'(gpio_oeb_a), 64'h0);
    des_dyn_en[2] = 0;
    tick;
    chk("dyn_low", 64'(gpio_oeb_a[7:0]), 64'hFF);
    chk("dyn_high", 64'(gpio_oeb_a[33:8]), 64'h0);
    des_dyn_en[2] = 1;
    design_sel = 1;
    tick;
    chk("sw_cs_off", 64'(des_cs_a), 64'h0);
    tick;
    chk("sw_oeb_off", 64'(gpio_oeb_a), 64'h3_FFFF_FFFF);
    design_sel = 3;
    wait_active(0, n);
    chk("restart_latency", 64'(n), 64'd5);
    chk("restart_cs", 64'(des_cs_a), 64'b1000);
    design_sel = 1;
    wait_active(0, n);
    chk("switch_latency", 64'(n), 64'd5);
    chk("switch_cs", 64'(des_cs_a), 64'b0010);
    design_sel = 3;
    repeat (8) tick;
    chk("bad_active", 64'(active_b), 64'h0);
    chk("bad_sel_err", 64'(sel_err_b), 64'h1);
    chk("bad_oeb", 64'(gpio_oeb_b), 64'h3_FFFF_FFFF);
    design_sel = 0;
    wait_active(1, n);
    chk("good_latency", 64'(n), 64'd5);
    chk("good_cs", 64'(des_cs_b), 64'b001);
    repeat (3) tick;
    rst = 1;
    tick;
    chk("rst_oeb", 64'(gpio_oeb_a), 64'h3_FFFF_FFFF);
    chk("rst_cs", 64'(des_cs_a), 64'h0);
    chk("rst_active", 64'(active_a), 64'h0);
    rst = 0;
    wait_active(0, n);
    chk("react_latency", 64'(n), 64'd7);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(39) == 0) ncs = !ncs;
      if ($urandom_range(24) == 0) design_sel = 2'($urandom);
      if ($urandom_range(9) == 0) des_dyn_en = 4'($urandom);
      if ($urandom_range(99) == 0) des_oeb_mask = 136'({$urandom, $urandom, $urandom, $urandom, $urandom});
      rst = $urandom_range(399) == 0;
      des_gpo = 136'({$urandom, $urandom, $urandom, $urandom, $urandom});
      gpio_in = 34'({$urandom, $urandom});
      tick;
    end
    rst = 0;
    ncs = 1;
    repeat (5) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_select_wrapper.md
Name: gpio_select_wrapper

Overview:
- Parametrised GPIO wrapper that multiplexes NUM_DESIGNS user designs onto one shared breakout-pin bank.
- Synchronises the external active-low chip select and decodes a design select into a one-hot per-design chip select.
- Enforces a guard interval with all pins tri-stated on every activation or design switch, and registers pin data and output enables.
- Sits between the top-level GPIO pads and the individual design cores.

Parameters:
- NUM_DESIGNS, 4, number of multiplexed designs (2..16).
- GPIO_W, 34, breakout pin count.
- SEL_W, $clog2(NUM_DESIGNS), design_sel width.
- DYN_W, 8, low pins whose direction each design controls dynamically (0..GPIO_W).
- GUARD_CYCLES, 4, tri-state cycles before a newly selected design drives pins (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ncs  input  1  external chip select, active low, asynchronous to clk
- design_sel  input  SEL_W  requested design index
- gpio_in  input  GPIO_W  pad inputs
- gpio_out  output  GPIO_W  pad outputs
- gpio_oeb  output  GPIO_W  pad output enable, active low
- des_gpo  input  NUM_DESIGNS*GPIO_W  per-design outputs; design d occupies slice [d*GPIO_W +: GPIO_W]
- des_oeb_mask  input  NUM_DESIGNS*GPIO_W  per-design static oeb (quasi-static tie-offs), same slicing
- des_dyn_en  input  NUM_DESIGNS  per-design dynamic output enable for pins [DYN_W-1:0]
- des_cs  output  NUM_DESIGNS  one-hot chip select to designs
- des_gpi  output  GPIO_W  gpio_in when ACTIVE, else 0
- active  output  1  state==ACTIVE
- sel_err  output  1  registered; set while synced cs=1 and design_sel>=NUM_DESIGNS

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values: state=IDLE, cur_sel=0, counter=0, both sync flops=0 (deasserted). Outputs: gpio_out=0, gpio_oeb=all 1, des_cs=0, active=0, sel_err=0.
- CS synchroniser: cs_s = ~ncs through two flops. 2-cycle latency. No glitch filtering beyond that.
- FSM states: IDLE, GUARD, ACTIVE.
- IDLE:
  - if cs_s=1 and design_sel<NUM_DESIGNS: cur_sel<=design_sel, cnt<=GUARD_CYCLES-1, go GUARD.
  - out-of-range select: stay IDLE.
- GUARD:
  - cs_s=0 -> IDLE.
  - design_sel valid and !=cur_sel -> reload cur_sel and cnt (restart guard).
  - design_sel out of range -> IDLE.
  - cnt==0 -> ACTIVE.
  - otherwise cnt--.
- ACTIVE:
  - cs_s=0 -> IDLE.
  - design_sel valid and !=cur_sel -> GUARD with new cur_sel and cnt reload.
  - design_sel out of range -> IDLE.
  - Priority: cs drop > out-of-range > sel change.
- des_cs = onehot(cur_sel) when state==ACTIVE, else 0. Decoded from state registers, so it asserts in the first ACTIVE cycle.
- Output register, updated every cycle:
  - state==ACTIVE: gpio_out <= des_gpo[cur_sel]. gpio_oeb[i] <= ~des_dyn_en[cur_sel] for i<DYN_W, else des_oeb_mask[cur_sel][i].
  - otherwise: gpio_out <= 0, gpio_oeb <= all 1.
  - Pin latency is one cycle after entering ACTIVE. Pins return to tri-state one cycle after leaving ACTIVE.
- Timing from ncs falling: 2 cycles to cs_s, then 1 cycle to GUARD, then GUARD_CYCLES cycles in GUARD, then ACTIVE; pins driven one cycle after that.
- des_gpi: combinational, gpio_in gated by active.
- Reset mid-operation: rst wins over every transition. Outputs reach reset values at the next edge.

Decomposition:
- Package gpio_wrap_pkg:
  - state_t enum {IDLE, GUARD, ACTIVE}.
  - Function onehot_dec.
  - Default-width localparams.
- Sub-module cs_sync2: 2-flop synchroniser with synchronous active-high reset to 0.
- FSM, counter and output mux live in the top.

Test Plan (all with defaults):
- Reset then idle: rst=1 for 2 cycles, ncs=1 -> gpio_oeb=34'h3_FFFF_FFFF, gpio_out=0, des_cs=0, active=0 indefinitely.
- Activation latency: ncs low, design_sel=2, des_gpo[2]=34'h1_2345_6789, des_oeb_mask[2]=0, des_dyn_en[2]=1 -> active and des_cs=4'b0100 exactly 7 cycles after ncs low (2 sync + 1 + 4 guard); gpio_out=34'h1_2345_6789 and gpio_oeb=0 on the following cycle.
- Dynamic direction: in ACTIVE toggle des_dyn_en[2] 1->0 -> gpio_oeb[7:0] goes 8'h00->8'hFF one cycle later; upper bits unchanged.
- Design switch: in ACTIVE change design_sel 2->1 -> des_cs=0 and gpio_oeb=all 1 next cycle; des_cs=4'b0010 after 4 guard cycles; sel change mid-guard restarts the 4-cycle count.
- Invalid select: NUM_DESIGNS=3, design_sel=3 with ncs low -> state stays IDLE, sel_err=1, pins tri-stated; design_sel=0 -> normal activation.
- Reset mid-ACTIVE: assert rst one cycle -> gpio_oeb all 1, des_cs=0, state IDLE at the next edge; re-activation takes the full 7 cycles.
